// File: rtl/regfile_mp_pkg.sv
// Shared types and defaults for the multi-port register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default widths/port counts, data_t/r_t, NULL/ZERO constants and the
// rf_wr_t writeback bundle for the default configuration.
package regfile_mp_pkg;

  localparam int XLEN     = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);
  localparam int NRD_DEF  = 2;
  localparam int NWR_DEF  = 2;

  typedef logic [XLEN-1:0]   data_t;
  typedef logic [AW_DEF-1:0] r_t;

  // Register index 0 is the hardwired-zero register.
  localparam r_t    NULL = '0;
  localparam data_t ZERO = '0;

  // One writeback port in the default configuration.
  typedef struct packed {
    logic  en;
    r_t    addr;
    data_t data;
  } rf_wr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Latency: issue sets busy at the next edge; writeback clears busy at the next edge.
// Backpressure: none; decode stalls on the busy bits, this block never stalls.
// Ports: clk, rst_n (async active-low), iss_en_i/iss_addr_i (new producer),
//        wr_en_i/wr_addr_i (writebacks), busy_o (registered busy vector, bit 0 = 0).
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter  int NREG = NREG_DEF,
  parameter  int NWR  = NWR_DEF,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    iss_en_i,
  input  logic [AW-1:0]           iss_addr_i,
  input  logic [NWR-1:0]          wr_en_i,
  input  logic [NWR-1:0][AW-1:0]  wr_addr_i,
  output logic [NREG-1:0]         busy_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Clears are applied first and the issue set last, so a new producer
  // issued in the same cycle as an older producer's writeback keeps the
  // register busy.
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en_i[p]) busy_d[wr_addr_i[p]] = 1'b0;
    end
    if (iss_en_i) busy_d[iss_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with pending-write scoreboard (x0 reads zero).
// Latency: reads combinational; writes land in the array at the edge (forwarded same cycle with REGFILE_BYPASS_EN).
// Backpressure: none; rd_busy_o tells decode to stall on an outstanding producer.
// Config macro: REGFILE_BYPASS_EN enables same-cycle write->read forwarding and
// masks rd_busy_o by a same-cycle writeback; undefined reads come from the array only.
// Ports: clk, rst_n; wr_en_i/wr_addr_i/wr_data_i (NWR writeback ports);
//        rd_en_i/rd_addr_i -> rd_data_o/rd_busy_o (NRD read ports);
//        iss_en_i/iss_addr_i (destination of an issued instruction); busy_any_o.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter  int XLEN = regfile_mp_pkg::XLEN,
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = NRD_DEF,
  parameter  int NWR  = NWR_DEF,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NWR-1:0]           wr_en_i,
  input  logic [NWR-1:0][AW-1:0]   wr_addr_i,
  input  logic [NWR-1:0][XLEN-1:0] wr_data_i,
  input  logic [NRD-1:0]           rd_en_i,
  input  logic [NRD-1:0][AW-1:0]   rd_addr_i,
  output logic [NRD-1:0][XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]           rd_busy_o,
  input  logic                     iss_en_i,
  input  logic [AW-1:0]            iss_addr_i,
  output logic                     busy_any_o
);

  // Writeback bundle sized for this instance.
  typedef struct packed {
    logic            en;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t [NWR-1:0]             wr;
  logic [NREG-1:0][XLEN-1:0] regs_q;
  logic [NREG-1:0][XLEN-1:0] regs_d;
  logic [NREG-1:0]           busy;

  always_comb begin
    for (int p = 0; p < NWR; p++) begin
      wr[p].en   = wr_en_i[p];
      wr[p].addr = wr_addr_i[p];
      wr[p].data = wr_data_i[p];
    end
  end

  // Ports are scanned in ascending order so the highest-numbered port wins
  // a same-address conflict. Index 0 is never written and stays zero.
  always_comb begin
    regs_d = regs_q;
    for (int p = 0; p < NWR; p++) begin
      if (wr[p].en && wr[p].addr != '0) regs_d[wr[p].addr] = wr[p].data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  regfile_scoreboard #(
    .NREG (NREG),
    .NWR  (NWR)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .iss_en_i   (iss_en_i),
    .iss_addr_i (iss_addr_i),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .busy_o     (busy)
  );

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_data_o[i] = '0;
      rd_busy_o[i] = 1'b0;
      if (rd_en_i[i] && rd_addr_i[i] != '0) begin
        rd_data_o[i] = regs_q[rd_addr_i[i]];
        rd_busy_o[i] = busy[rd_addr_i[i]];
`ifdef REGFILE_BYPASS_EN
        // Writes during reset are dropped, so they are not forwarded either;
        // this keeps rd_data_o at zero while rst_n is low.
        for (int p = 0; p < NWR; p++) begin
          if (rst_n && wr[p].en && wr[p].addr == rd_addr_i[i]) begin
            rd_data_o[i] = wr[p].data;
            rd_busy_o[i] = 1'b0;
          end
        end
`endif
      end
    end
  end

  assign busy_any_o = |busy;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic             clk;
  logic             rst_n;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][31:0] wr_data;
  logic [1:0]       rd_en;
  logic [1:0][4:0]  rd_addr;
  logic [1:0][31:0] rd_data;
  logic [1:0]       rd_busy;
  logic             iss_en;
  logic [4:0]       iss_addr;
  logic             busy_any;

  int n_checks;
  int n_fail;

  regfile_mp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .rd_en_i    (rd_en),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .rd_busy_o  (rd_busy),
    .iss_en_i   (iss_en),
    .iss_addr_i (iss_addr),
    .busy_any_o (busy_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    wr_en = '0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    rd_en = 2'b11; rd_addr[0] = 5'd5; rd_addr[1] = 5'd5;
    #2;
    n_checks++;
    if (rd_data !== 64'h0 || rd_busy !== 2'b00 || busy_any !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_during: rd_data=%h rd_busy=%b busy_any=%b required 0/00/0", rd_data, rd_busy, busy_any);
    end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (rd_data !== 64'h0 || rd_busy !== 2'b00 || busy_any !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after: rd_data=%h rd_busy=%b busy_any=%b required 0/00/0", rd_data, rd_busy, busy_any);
    end
  endtask

  task automatic test_write_fwd();
    logic [31:0] exp_same;
    next_cycle();
    wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEAD_BEEF;
    rd_en = 2'b11; rd_addr[0] = 5'd5; rd_addr[1] = 5'd5;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'hDEAD_BEEF;
`else
    exp_same = 32'h0;
`endif
    @(negedge clk);
    n_checks++;
    if (rd_data[0] !== exp_same) begin
      n_fail++;
      $display("FAIL wr_x5_same_cycle: got %h required %h", rd_data[0], exp_same);
    end
    next_cycle();
    idle();
    @(negedge clk);
    n_checks++;
    if (rd_data[0] !== 32'hDEAD_BEEF || rd_data[1] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL wr_x5_array: got %h/%h required deadbeef/deadbeef", rd_data[0], rd_data[1]);
    end
  endtask

  task automatic test_conflict_x0();
    logic [31:0] exp_same;
    next_cycle();
    wr_en = 2'b11;
    wr_addr[0] = 5'd7; wr_data[0] = 32'h1111;
    wr_addr[1] = 5'd7; wr_data[1] = 32'h2222;
    rd_en = 2'b11; rd_addr[0] = 5'd7; rd_addr[1] = 5'd7;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h2222;
`else
    exp_same = 32'h0;
`endif
    @(negedge clk);
    n_checks++;
    if (rd_data[1] !== exp_same) begin
      n_fail++;
      $display("FAIL conflict_fwd: got %h required %h", rd_data[1], exp_same);
    end
    next_cycle();
    idle();
    @(negedge clk);
    n_checks++;
    if (rd_data[0] !== 32'h2222) begin
      n_fail++;
      $display("FAIL conflict_array: got %h required 00002222", rd_data[0]);
    end
    next_cycle();
    wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFF;
    iss_en = 1'b1; iss_addr = 5'd0;
    rd_en = 2'b01; rd_addr[0] = 5'd0;
    @(negedge clk);
    n_checks++;
    if (rd_data[0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_same_cycle: data=%h busy=%b required 0/0", rd_data[0], rd_busy[0]);
    end
    next_cycle();
    idle();
    @(negedge clk);
    n_checks++;
    if (rd_data[0] !== 32'h0 || busy_any !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_after: data=%h busy_any=%b required 0/0", rd_data[0], busy_any);
    end
  endtask

  task automatic test_scoreboard();
    logic        exp_busy4;
    logic [31:0] exp_data4;
    next_cycle();
    // cycle 1: issue x3
    iss_en = 1'b1; iss_addr = 5'd3;
    rd_en = 2'b01; rd_addr[0] = 5'd3;
    @(negedge clk);
    n_checks++;
    if (rd_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_cycle1: rd_busy=%b required 0", rd_busy[0]);
    end
    next_cycle();
    idle();
    // cycle 2
    @(negedge clk);
    n_checks++;
    if (rd_busy[0] !== 1'b1 || busy_any !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_cycle2: rd_busy=%b busy_any=%b required 1/1", rd_busy[0], busy_any);
    end
    next_cycle();
    // cycle 3
    @(negedge clk);
    n_checks++;
    if (rd_busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL sb_cycle3: rd_busy=%b required 1", rd_busy[0]);
    end
    next_cycle();
    // cycle 4: writeback of x3
    wr_en = 2'b10; wr_addr[1] = 5'd3; wr_data[1] = 32'h42;
`ifdef REGFILE_BYPASS_EN
    exp_busy4 = 1'b0; exp_data4 = 32'h42;
`else
    exp_busy4 = 1'b1; exp_data4 = 32'h0;
`endif
    @(negedge clk);
    n_checks++;
    if (rd_busy[0] !== exp_busy4 || rd_data[0] !== exp_data4) begin
      n_fail++;
      $display("FAIL sb_cycle4: rd_busy=%b data=%h required %b/%h", rd_busy[0], rd_data[0], exp_busy4, exp_data4);
    end
    next_cycle();
    idle();
    // cycle 5
    @(negedge clk);
    n_checks++;
    if (rd_busy[0] !== 1'b0 || rd_data[0] !== 32'h42 || busy_any !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_cycle5: rd_busy=%b data=%h busy_any=%b required 0/42/0", rd_busy[0], rd_data[0], busy_any);
    end
  endtask

  task automatic test_iss_wr_same();
    next_cycle();
    iss_en = 1'b1; iss_addr = 5'd9;
    next_cycle();
    iss_en = 1'b1; iss_addr = 5'd9;
    wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h10;
    next_cycle();
    idle();
    rd_en = 2'b01; rd_addr[0] = 5'd9;
    @(negedge clk);
    n_checks++;
    if (rd_busy[0] !== 1'b1 || busy_any !== 1'b1 || rd_data[0] !== 32'h10) begin
      n_fail++;
      $display("FAIL iss_wr_same: rd_busy=%b busy_any=%b data=%h required 1/1/10", rd_busy[0], busy_any, rd_data[0]);
    end
    // Drain x9 so later tests start clean.
    next_cycle();
    wr_en = 2'b01; wr_addr[0] = 5'd9; wr_data[0] = 32'h10;
    next_cycle();
    idle();
    @(negedge clk);
    n_checks++;
    if (busy_any !== 1'b0) begin
      n_fail++;
      $display("FAIL iss_wr_drain: busy_any=%b required 0", busy_any);
    end
  endtask

  task automatic test_rd_disable();
    next_cycle();
    wr_en = 2'b01; wr_addr[0] = 5'd4; wr_data[0] = 32'h55;
    next_cycle();
    idle();
    iss_en = 1'b1; iss_addr = 5'd4;
    next_cycle();
    idle();
    rd_en = 2'b10; rd_addr[0] = 5'd4; rd_addr[1] = 5'd4;
    @(negedge clk);
    n_checks++;
    if (rd_data[0] !== 32'h0 || rd_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_disabled: data=%h busy=%b required 0/0", rd_data[0], rd_busy[0]);
    end
    n_checks++;
    if (rd_data[1] !== 32'h55 || rd_busy[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_enabled: data=%h busy=%b required 55/1", rd_data[1], rd_busy[1]);
    end
  endtask

  task automatic test_visibility_x6();
    logic [31:0] exp_same;
    next_cycle();
    wr_en = 2'b01; wr_addr[0] = 5'd6; wr_data[0] = 32'h1;
    next_cycle();
    wr_en = 2'b10; wr_addr[1] = 5'd6; wr_data[1] = 32'hABCD;
    wr_addr[0] = 5'd0;
    rd_en = 2'b01; rd_addr[0] = 5'd6;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'hABCD;
`else
    exp_same = 32'h1;
`endif
    @(negedge clk);
    n_checks++;
    if (rd_data[0] !== exp_same) begin
      n_fail++;
      $display("FAIL x6_edge_n: got %h required %h", rd_data[0], exp_same);
    end
    next_cycle();
    idle();
    @(negedge clk);
    n_checks++;
    if (rd_data[0] !== 32'hABCD) begin
      n_fail++;
      $display("FAIL x6_edge_n1: got %h required 0000abcd", rd_data[0]);
    end
  endtask

  task automatic test_reset_mid();
    // x4 is still busy from the read-enable test.
    next_cycle();
    iss_en = 1'b1; iss_addr = 5'd12;
    wr_en = 2'b01; wr_addr[0] = 5'd6; wr_data[0] = 32'h77;
    rd_en = 2'b11; rd_addr[0] = 5'd6; rd_addr[1] = 5'd5;
    #1;
    n_checks++;
    if (busy_any !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_busy: busy_any=%b required 1", busy_any);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rd_data !== 64'h0 || rd_busy !== 2'b00 || busy_any !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: rd_data=%h rd_busy=%b busy_any=%b required 0/00/0", rd_data, rd_busy, busy_any);
    end
    next_cycle();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    rd_addr[1] = 5'd7;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (rd_data !== 64'h0 || busy_any !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_after: rd_data=%h busy_any=%b required 0/0", rd_data, busy_any);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    rd_en = '0;
    rd_addr = '0;
    idle();
    test_reset();
    test_write_fwd();
    test_conflict_x0();
    test_scoreboard();
    test_iss_wr_same();
    test_rd_disable();
    test_visibility_x6();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
